// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - VGA scan-out engine; optional colour-bar source under VGA_SCAN_TEST_PATTERN_EN
module vga_scan_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_WIDTH    = 160,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 24,
    parameter int RD_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_en,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  front_sel,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  frame_start,
    output logic [DATA_W/3-1:0]   vga_r,
    output logic [DATA_W/3-1:0]   vga_g,
    output logic [DATA_W/3-1:0]   vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_blank_n,
    output logic                  vga_sync_n,
    output logic                  vga_clk_en
`ifdef VGA_SCAN_TEST_PATTERN_EN
    ,
    input  logic                  test_mode
`endif
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W        = $clog2(H_TOTAL);
    localparam int V_W        = $clog2(V_TOTAL);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_W        = DATA_W / 3;
    localparam int HS_START   = H_ACTIVE + H_FP;
    localparam int HS_END     = HS_START + H_SYNC;
    localparam int VS_START   = V_ACTIVE + V_FP;
    localparam int VS_END     = VS_START + V_SYNC;
    localparam int SCALE_MASK = (1 << SCALE_SHIFT) - 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [H_W-1:0]    h;
    logic [V_W-1:0]    v;
    logic [ADDR_W-1:0] row_base;

    logic              tick;
    logic              h_last;
    logic              v_last;
    logic              row_step;
    logic              active_now;
    logic              hs_now;
    logic              vs_now;
    logic              rd_gate;
    logic [ADDR_W-1:0] addr_now;

    logic              act0;
    logic              hs0;
    logic              vs0;
    logic [RD_LAT-1:0] act_d;
    logic [RD_LAT-1:0] hs_d;
    logic [RD_LAT-1:0] vs_d;

    assign tick       = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_last     = (int'(h) == H_TOTAL - 1);
    assign v_last     = (int'(v) == V_TOTAL - 1);
    // Row base steps by one stride each time v enters a new framebuffer row
    assign row_step   = ((v & V_W'(SCALE_MASK)) == V_W'(SCALE_MASK));
    assign active_now = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign hs_now     = !((int'(h) >= HS_START) && (int'(h) < HS_END));
    assign vs_now     = !((int'(v) >= VS_START) && (int'(v) < VS_END));
    assign addr_now   = row_base + ADDR_W'(h >> SCALE_SHIFT);

    assign vga_hs      = hs_d[RD_LAT-1];
    assign vga_vs      = vs_d[RD_LAT-1];
    assign vga_blank_n = act_d[RD_LAT-1];
    assign vga_sync_n  = 1'b0;
    assign vga_clk_en  = tick;

    // Pixel divider, h/v scan counters and the row-base accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            h        <= '0;
            v        <= '0;
            row_base <= '0;
        end else if (!enable) begin
            div_cnt  <= '0;
            h        <= '0;
            v        <= '0;
            row_base <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v        <= '0;
                    row_base <= '0;
                end else begin
                    v <= v + V_W'(1);
                    if (row_step)
                        row_base <= row_base + ADDR_W'(FB_WIDTH);
                end
            end else begin
                h <= h + H_W'(1);
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Read request stage, frame marker and vblank-aligned buffer swap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            act0        <= 1'b0;
            hs0         <= 1'b1;
            vs0         <= 1'b1;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            front_sel   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            if (!enable) begin
                rd_addr <= '0;
                rd_en   <= 1'b0;
                act0    <= 1'b0;
                hs0     <= 1'b1;
                vs0     <= 1'b1;
            end else if (tick) begin
                rd_addr     <= addr_now;
                rd_en       <= active_now && rd_gate;
                act0        <= active_now;
                hs0         <= hs_now;
                vs0         <= vs_now;
                frame_start <= (h == '0) && (v == '0);
                if ((h == '0) && (int'(v) == V_ACTIVE) && swap_req) begin
                    front_sel <= ~front_sel;
                    swap_ack  <= 1'b1;
                end
            end
        end
    end

    // Delay sync and blank by the RAM latency so they line up with rd_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_d <= '0;
            hs_d  <= '1;
            vs_d  <= '1;
        end else if (!enable) begin
            act_d <= '0;
            hs_d  <= '1;
            vs_d  <= '1;
        end else if (tick) begin
            act_d[0] <= act0;
            hs_d[0]  <= hs0;
            vs_d[0]  <= vs0;
            for (int i = 1; i < RD_LAT; i++) begin
                act_d[i] <= act_d[i-1];
                hs_d[i]  <= hs_d[i-1];
                vs_d[i]  <= vs_d[i-1];
            end
        end
    end

`ifdef VGA_SCAN_TEST_PATTERN_EN
    logic [2:0]        bar_now;
    logic [2:0]        bar0;
    logic              pat0;
    logic [2:0]        bar_d [RD_LAT];
    logic [RD_LAT-1:0] pat_d;

    assign rd_gate = !test_mode;

    // Bar index h*8/H_ACTIVE as a count of crossed bar boundaries
    always_comb begin
        bar_now = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(h) * 8 >= k * H_ACTIVE)
                bar_now = bar_now + 3'd1;
        end
    end

    // Pattern select and bar index travel alongside the blank pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar0  <= '0;
            pat0  <= 1'b0;
            pat_d <= '0;
            for (int i = 0; i < RD_LAT; i++)
                bar_d[i] <= '0;
        end else if (!enable) begin
            bar0  <= '0;
            pat0  <= 1'b0;
            pat_d <= '0;
            for (int i = 0; i < RD_LAT; i++)
                bar_d[i] <= '0;
        end else if (tick) begin
            bar0     <= bar_now;
            pat0     <= test_mode;
            bar_d[0] <= bar0;
            pat_d[0] <= pat0;
            for (int i = 1; i < RD_LAT; i++) begin
                bar_d[i] <= bar_d[i-1];
                pat_d[i] <= pat_d[i-1];
            end
        end
    end
`else
    assign rd_gate = 1'b1;
`endif

    // Colour mux: framebuffer data (or bars) inside the active area, black outside
    always_comb begin
        vga_r = '0;
        vga_g = '0;
        vga_b = '0;
        if (act_d[RD_LAT-1]) begin
            vga_r = rd_data[3*C_W-1:2*C_W];
            vga_g = rd_data[2*C_W-1:C_W];
            vga_b = rd_data[C_W-1:0];
`ifdef VGA_SCAN_TEST_PATTERN_EN
            if (pat_d[RD_LAT-1]) begin
                vga_r = {C_W{bar_d[RD_LAT-1][2]}};
                vga_g = {C_W{bar_d[RD_LAT-1][1]}};
                vga_b = {C_W{bar_d[RD_LAT-1][0]}};
            end
`endif
        end
    end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
Parametrised VGA scan-out engine: timing generation, integer pixel-scale framebuffer address generation, read-latency alignment and a vblank-synchronised double-buffer swap handshake. Sits between the frame buffer RAM (read port) and the VGA DAC pins. Runs on the system clock with an internal pixel-tick enable; no derived clocks.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
SCALE_SHIFT, 2, each framebuffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
FB_WIDTH, 160, framebuffer row stride in words
ADDR_W, 15, read address width
DATA_W, 24, pixel word width ({r,g,b}, DATA_W/3 bits each)
RD_LAT, 1, RAM read latency in pixel ticks (1..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  0: counters held at 0, outputs blanked
rd_addr  out  ADDR_W  framebuffer read address
rd_en  out  1  read strobe, high on pixel ticks inside active area
rd_data  in  DATA_W  RAM data, valid RD_LAT ticks after rd_en
front_sel  out  1  buffer currently displayed
swap_req  in  1  level request to swap buffers
swap_ack  out  1  one-clk pulse when swap performed
frame_start  out  1  one-clk pulse at pixel tick of (x=0,y=0)
vga_r, vga_g, vga_b  out  DATA_W/3 each  colour outputs
vga_hs, vga_vs  out  1  sync, active-low
vga_blank_n  out  1  low outside active area
vga_sync_n  out  1  tied 0
vga_clk_en  out  1  pixel tick (DAC latch qualifier)

Behaviour:
- Reset (rst=0): all counters 0, front_sel=0, swap_ack=0, frame_start=0, rd_en=0, rd_addr=0, colours 0, vga_hs=vga_vs=1, vga_blank_n=0. Async assert, sync deassert release on clk.
- Pixel tick: divider counts 0..CLK_DIV-1; tick when count==CLK_DIV-1. CLK_DIV=1 -> tick every clk.
- h counter 0..H_TOTAL-1 (H_TOTAL=sum of H params), advances on tick; wrap advances v counter 0..V_TOTAL-1; both wrap to 0 together.
- hs low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise for v. active = h<H_ACTIVE && v<V_ACTIVE.
- Address: rd_addr = (v>>SCALE_SHIFT)*FB_WIDTH + (h>>SCALE_SHIFT), computed at full ADDR_W, truncated; no multiplier required (stride via adder/accumulator permitted). rd_addr registered, updated on tick; rd_en = active on that tick.
- Alignment: hs, vs, active delayed RD_LAT ticks in a shift pipeline so colours, sync and blank emerge together. Colours = rd_data when delayed active, else 0.
- Swap: sampled on the tick where h==0 and v==V_ACTIVE (first blank line). If swap_req=1: front_sel toggles, swap_ack pulses 1 clk same cycle. Requester holds swap_req until ack; swap_req rising mid-frame waits for next vblank; swap_req held high continuously -> one swap per frame.
- frame_start: 1-clk pulse on tick with h==0,v==0 (undelayed).
- enable falling: counters and pipeline cleared next clk, outputs as reset except front_sel retained; pending swap not taken.
- enable rising: scan restarts at (0,0); first frame_start on first tick.

Optional Feature:
Macro VGA_SCAN_TEST_PATTERN_EN. Defined: extra input test_mode (1 bit); when 1, colours in active area come from 8 vertical colour bars (bar = h*8/H_ACTIVE, r/g/b = all-ones or 0 per bits 2/1/0 of bar index), rd_en forced 0, timing unchanged. Undefined: port absent, colours always from rd_data.

Test Plan:
- Default params, enable=1: measure vga_hs period = 800*2 = 1600 clk, low 192 clk; vga_vs period 525 lines, low 2 lines.
- rd_data = rd_addr echoed by model with RD_LAT=1: pixel (x=13,y=9) shows value 2*160+3=323; blank_n low at x=640.
- swap_req raised at line 100 -> swap_ack pulse and front_sel 0->1 exactly at h=0,v=480; held high two frames -> two toggles.
- RD_LAT=3, CLK_DIV=1: blank_n/hs edges shift 3 clk vs undelayed counter; colour edges coincide with blank_n edges.
- rst asserted mid-line (h=300) -> all outputs to reset values same cycle asynchronously; release -> frame_start after first tick.
- With VGA_SCAN_TEST_PATTERN_EN, test_mode=1: x=0 colour 0, x=639 all-ones, rd_en never asserted.
